// File: rtl/cla_adder_pipe_if.sv
// Handshake bundle for cla_adder_pipe: operand channel in, result channel out.
// The slave modport is the adder; the master modport is whoever feeds and drains it.
interface cla_adder_pipe_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );
endinterface

// File: rtl/cla_adder_pipe.sv
// Two-stage pipelined carry-lookahead adder/subtractor: stage 1 resolves group carry-ins,
// stage 2 expands them to bit carries and forms sum, carry-out and signed overflow.
module cla_adder_pipe #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned GROUP = 4
) (
  input logic             clk,
  input logic             rst_n,
  cla_adder_pipe_if.slave bus
);
  localparam int unsigned NG = WIDTH / GROUP;

  if (GROUP != 4) begin : gen_bad_group
    $error("cla_adder_pipe: GROUP must be 4");
  end
  if ((WIDTH % 4) != 0 || WIDTH < 4) begin : gen_bad_width
    $error("cla_adder_pipe: WIDTH must be a non-zero multiple of 4");
  end

  // Group generate; p is the alive (OR) form, which is valid for generate/carry terms.
  function automatic logic grp_gen(input logic [3:0] g, input logic [3:0] p);
    return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  endfunction

  // Flattened lookahead: carries into bits 0..3 plus the group carry-out in [4].
  function automatic logic [4:0] grp_carry(input logic [3:0] g, input logic [3:0] p,
                                           input logic c);
    logic [4:0] cy;
    cy[0] = c;
    cy[1] = g[0] | (p[0] & c);
    cy[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
    cy[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
    cy[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
          | (p[3] & p[2] & p[1] & p[0] & c);
    return cy;
  endfunction

  logic s1_valid_q, s2_valid_q;
  logic s1_adv, s2_adv, in_fire, s2_load;

  assign s2_adv       = ~s2_valid_q | bus.out_ready;
  assign s1_adv       = ~s1_valid_q | s2_adv;
  assign in_fire      = bus.in_valid & s1_adv;
  assign s2_load      = s1_valid_q & s2_adv;
  assign bus.in_ready = s1_adv;

  // Stage 1 combinational: operand preparation and second-level lookahead.
  logic [WIDTH-1:0] b_eff, g_d, p_d, t_d;
  logic             c0;
  logic [NG-1:0]    gc_d;

  assign b_eff = bus.in_sub ? ~bus.in_b : bus.in_b;
  assign c0    = bus.in_sub | bus.in_cin;
  assign g_d   = bus.in_a & b_eff;
  assign p_d   = bus.in_a | b_eff;
  assign t_d   = bus.in_a ^ b_eff;

  always_comb begin
    gc_d    = '0;
    gc_d[0] = c0;
    for (int unsigned k = 0; k + 1 < NG; k++) begin
      gc_d[k+1] = grp_gen(g_d[4*k +: 4], p_d[4*k +: 4]) | ((&p_d[4*k +: 4]) & gc_d[k]);
    end
  end

  logic [WIDTH-1:0] g_q, p_q, t_q;
  logic [NG-1:0]    gc_q;
  logic             a_msb_q, b_msb_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      g_q        <= '0;
      p_q        <= '0;
      t_q        <= '0;
      gc_q       <= '0;
      a_msb_q    <= 1'b0;
      b_msb_q    <= 1'b0;
    end else begin
      if (s1_adv) s1_valid_q <= bus.in_valid;
      if (in_fire) begin
        g_q     <= g_d;
        p_q     <= p_d;
        t_q     <= t_d;
        gc_q    <= gc_d;
        a_msb_q <= bus.in_a[WIDTH-1];
        b_msb_q <= b_eff[WIDTH-1];
      end
    end
  end

  // Stage 2 combinational: per-group bit carries from the registered group carry-in.
  logic [WIDTH-1:0] carry, sum_d;
  logic [4:0]       cy;
  logic             cout_d, ovf_d;

  always_comb begin
    carry  = '0;
    cy     = '0;
    cout_d = 1'b0;
    for (int unsigned k = 0; k < NG; k++) begin
      cy                = grp_carry(g_q[4*k +: 4], p_q[4*k +: 4], gc_q[k]);
      carry[4*k +: 4]   = cy[3:0];
      cout_d            = cy[4];  // last iteration is the top group
    end
    sum_d = t_q ^ carry;
    ovf_d = (a_msb_q == b_msb_q) & (sum_d[WIDTH-1] != a_msb_q);
  end

  logic [WIDTH-1:0] sum_q;
  logic             cout_q, ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      if (s2_adv) s2_valid_q <= s1_valid_q;
      if (s2_load) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
        ovf_q  <= ovf_d;
      end
    end
  end

  assign bus.out_valid = s2_valid_q;
  assign bus.out_sum   = sum_q;
  assign bus.out_cout  = cout_q;
  assign bus.out_ovf   = ovf_q;
endmodule
